// File: rtl/host_sequencer_pkg.sv
// Shared state encodings and bus/SPM field offsets for host_sequencer.
package host_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CFG,
    S_LOAD,
    S_RUN_HI,
    S_RUN_GAP,
    S_DONE
  } seq_state_e;

  function automatic int exb_data_lo();
    return 0;
  endfunction

  function automatic int exb_addr_lo(int d_w);
    return d_w;
  endfunction

  function automatic int exb_ren(int a_w, int d_w);
    return a_w + d_w;
  endfunction

  function automatic int exb_wen(int a_w, int d_w);
    return a_w + d_w + 1;
  endfunction

  // SPM config: four 5-bit bank slices {mode, sel[1:0], en, fifo_sel}
  localparam int SPM_BANKS    = 4;
  localparam int SPM_BANK_W   = 5;
  localparam int SPM_FIFO_SEL = 0;
  localparam int SPM_EN       = 1;
  localparam int SPM_SEL      = 2;
  localparam int SPM_MODE     = 4;

  function automatic int spm_bit(int bank, int field);
    return bank * SPM_BANK_W + field;
  endfunction

endpackage

// File: rtl/host_seq_pulse_gen.sv
// Run-pulse train generator: num pulses, each followed by gap low cycles.
module host_seq_pulse_gen #(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [LEN_W-1:0] num,
  input  logic [LEN_W-1:0] gap,
  output logic             run,
  output logic             finished,
  output logic             gap_end
);

  logic             in_gap;
  logic [LEN_W-1:0] left;
  logic [LEN_W-1:0] gcnt;

  assign finished = run && (left == LEN_W'(1));
  assign gap_end  = in_gap && (gcnt == LEN_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run    <= 1'b0;
      in_gap <= 1'b0;
      left   <= '0;
      gcnt   <= '0;
    end else if (abort) begin
      run    <= 1'b0;
      in_gap <= 1'b0;
      left   <= '0;
      gcnt   <= '0;
    end else if (start) begin
      run    <= 1'b1;
      in_gap <= 1'b0;
      left   <= num;
    end else if (run) begin
      left <= left - LEN_W'(1);
      if (finished) begin
        run <= 1'b0;
      end else if (gap == '0) begin
        run <= 1'b1;
      end else begin
        run    <= 1'b0;
        in_gap <= 1'b1;
        gcnt   <= gap;
      end
    end else if (in_gap) begin
      gcnt <= gcnt - LEN_W'(1);
      if (gap_end) begin
        in_gap <= 1'b0;
        run    <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/host_sequencer.sv
// CGRA host sequencer: config load, SPM data stream, run-pulse train.
// Optional HOST_SEQ_PERF_EN adds the run_cycles counter port.
module host_sequencer
  import host_sequencer_pkg::*;
#(
  parameter int ROWS  = 4,
  parameter int CFG_W = 96,
  parameter int SPM_W = 20,
  parameter int A_W   = 10,
  parameter int D_W   = 32,
  parameter int LEN_W = 16,
  localparam int IDX_W = $clog2(ROWS + 1),
  localparam int HC_W  = SPM_W + ROWS * CFG_W,
  localparam int EB_W  = 2 + A_W + D_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [A_W-1:0]   load_base,
  input  logic [LEN_W-1:0] load_len,
  input  logic [LEN_W-1:0] run_num,
  input  logic [LEN_W-1:0] run_gap,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [IDX_W-1:0] cfg_idx,
  input  logic [CFG_W-1:0] cfg_data,
  input  logic             cfg_last,
  input  logic             dat_valid,
  output logic             dat_ready,
  input  logic [D_W-1:0]   dat_data,
  output logic             init,
  output logic             run,
  output logic [HC_W-1:0]  host_controller,
  output logic [EB_W-1:0]  ex_bus,
  output logic             busy,
  output logic             done
`ifdef HOST_SEQ_PERF_EN
  ,
  output logic [31:0]      run_cycles
`endif
);

  localparam int EB_WEN  = exb_wen(A_W, D_W);
  localparam int EB_REN  = exb_ren(A_W, D_W);
  localparam int EB_ADDR = exb_addr_lo(D_W);
  localparam int EB_DATA = exb_data_lo();

  seq_state_e       state;
  logic [A_W-1:0]   base_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] num_q;
  logic [LEN_W-1:0] gap_q;
  logic [LEN_W-1:0] cnt;
  logic             wen_q;
  logic [A_W-1:0]   addr_q;
  logic [D_W-1:0]   data_q;
  logic             cfg_fire;
  logic             dat_fire;
  logic             load_last;
  logic             pg_start;
  logic             pg_finished;
  logic             pg_gap_end;

  assign cfg_fire  = (state == S_CFG) && cfg_valid;
  assign dat_fire  = (state == S_LOAD) && dat_valid;
  assign load_last = cnt == (len_q - LEN_W'(1));

  always_comb begin
    pg_start = 1'b0;
    if (!abort && num_q != '0) begin
      if (cfg_fire && cfg_last && len_q == '0)
        pg_start = 1'b1;
      if (dat_fire && load_last)
        pg_start = 1'b1;
    end
  end

  always_comb begin
    ex_bus                   = '0;
    ex_bus[EB_WEN]           = wen_q;
    ex_bus[EB_REN]           = 1'b0;
    ex_bus[EB_ADDR +: A_W]   = addr_q;
    ex_bus[EB_DATA +: D_W]   = data_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= S_IDLE;
      base_q          <= '0;
      len_q           <= '0;
      num_q           <= '0;
      gap_q           <= '0;
      cnt             <= '0;
      init            <= 1'b0;
      cfg_ready       <= 1'b0;
      dat_ready       <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      wen_q           <= 1'b0;
      addr_q          <= '0;
      data_q          <= '0;
      host_controller <= '0;
    end else if (abort) begin
      state     <= S_IDLE;
      cnt       <= '0;
      init      <= 1'b0;
      cfg_ready <= 1'b0;
      dat_ready <= 1'b0;
      busy      <= 1'b0;
      wen_q     <= 1'b0;
    end else begin
      wen_q <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            base_q    <= load_base;
            len_q     <= load_len;
            num_q     <= run_num;
            gap_q     <= run_gap;
            cnt       <= '0;
            init      <= 1'b1;
            cfg_ready <= 1'b1;
            busy      <= 1'b1;
            done      <= 1'b0;
            state     <= S_CFG;
          end
        end
        S_CFG: begin
          if (cfg_fire) begin
            unique case (1'b1)
              (cfg_idx < IDX_W'(ROWS)):
                host_controller[int'(cfg_idx) * CFG_W +: CFG_W] <= cfg_data;
              (cfg_idx == IDX_W'(ROWS)):
                host_controller[ROWS * CFG_W +: SPM_W] <= cfg_data[SPM_W-1:0];
              default: ;
            endcase
            if (cfg_last) begin
              init      <= 1'b0;
              cfg_ready <= 1'b0;
              if (len_q != '0) begin
                dat_ready <= 1'b1;
                state     <= S_LOAD;
              end else if (num_q != '0) begin
                state <= S_RUN_HI;
              end else begin
                done  <= 1'b1;
                state <= S_DONE;
              end
            end
          end
        end
        S_LOAD: begin
          if (dat_fire) begin
            wen_q  <= 1'b1;
            addr_q <= base_q + A_W'(cnt);
            data_q <= dat_data;
            cnt    <= cnt + LEN_W'(1);
            if (load_last) begin
              dat_ready <= 1'b0;
              if (num_q != '0) begin
                state <= S_RUN_HI;
              end else begin
                done  <= 1'b1;
                state <= S_DONE;
              end
            end
          end
        end
        S_RUN_HI: begin
          if (pg_finished) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else if (gap_q != '0) begin
            state <= S_RUN_GAP;
          end
        end
        S_RUN_GAP: begin
          if (pg_gap_end)
            state <= S_RUN_HI;
        end
        S_DONE: begin
          busy  <= 1'b0;
          cnt   <= '0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  host_seq_pulse_gen #(
    .LEN_W(LEN_W)
  ) u_pulse (
    .clk      (clk),
    .rst      (rst),
    .start    (pg_start),
    .abort    (abort),
    .num      (num_q),
    .gap      (gap_q),
    .run      (run),
    .finished (pg_finished),
    .gap_end  (pg_gap_end)
  );

`ifdef HOST_SEQ_PERF_EN
  // abort does not clear it so a partial count stays visible
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      run_cycles <= '0;
    else if (state == S_IDLE && start && !abort)
      run_cycles <= '0;
    else if ((state == S_RUN_HI || state == S_RUN_GAP) && run_cycles != '1)
      run_cycles <= run_cycles + 32'd1;
  end
`endif

endmodule

// File: doc/host_sequencer.md
# host_sequencer

Synthesizable host-side sequencer for the CGRA array. It loads per-row PE/LSU configuration words and the scratchpad (SPM) configuration, and streams a block of data words into SPM over the external bus. It then issues a programmable train of `run` pulses. It sits between the host interface and the `Delay`/`TCAD` pair, and drives the same `init`, `run`, `host_controller` and `ex_bus` signals, generalised in row count, widths and run schedule.

## Interface
- `ROWS`, 4: number of config-buffer rows.
- `CFG_W`, 96: width of one row config word (LSU inst plus 4 PE insts).
- `SPM_W`, 20: width of the SPM/scratchpad config word.
- `A_W`, 10: external-bus address width.
- `D_W`, 32: external-bus data width.
- `LEN_W`, 16: width of the load-length, run-count and run-gap fields.
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: begin a sequence; honoured only in IDLE.
- `abort` in 1: return to IDLE from any state.
- `load_base` in A_W: first SPM address; sampled at start.
- `load_len` in LEN_W: number of data words; sampled at start.
- `run_num` in LEN_W: number of run pulses; sampled at start.
- `run_gap` in LEN_W: low cycles between pulses; sampled at start.
- `cfg_valid` in 1: config word valid.
- `cfg_ready` out 1: config word accepted.
- `cfg_idx` in clog2(ROWS+1): 0..ROWS-1 selects a row; ROWS selects the SPM config.
- `cfg_data` in CFG_W: config word; low SPM_W bits are used when idx==ROWS.
- `cfg_last` in 1: final config word of the sequence.
- `dat_valid` in 1: load data valid.
- `dat_ready` out 1: load data accepted.
- `dat_data` in D_W: load data.
- `init` out 1: configuration phase active.
- `run` out 1: run pulse.
- `host_controller` out SPM_W+ROWS*CFG_W: {spm_cfg, row[ROWS-1], …, row[0]}.
- `ex_bus` out 2+A_W+D_W: {wen, ren, addr, data}.
- `busy` out 1: state is not IDLE.
- `done` out 1: sequence completed; held until the next start.

## Operation
- FSM states: IDLE, CFG, LOAD, RUN_HI, RUN_GAP, DONE. DONE falls through to IDLE in one cycle.
- IDLE + start: latch base, len, num and gap; go to CFG; clear `done`.
- CFG: `init`=1 and `cfg_ready`=1. On handshake, write the selected register. An out-of-range idx (>ROWS) is accepted and discarded.
  - Handshake with `cfg_last` goes to LOAD, or to RUN_HI if len==0, or to DONE if len==0 and num==0.
- LOAD: `dat_ready`=1. Each handshake registers wen=1, addr=base+cnt (mod 2^A_W, wraps), data=dat_data. `cnt` increments.
  - A cycle with no handshake leaves wen=0, with addr/data held.
  - The handshake with cnt==len-1 goes to RUN_HI, or to DONE if num==0.
- RUN_HI: `run`=1 for one cycle; decrement the pulse count.
  - If pulses remain: go to RUN_GAP when gap>0, or stay in RUN_HI (back-to-back pulses) when gap==0.
  - Otherwise go to DONE.
- RUN_GAP: `run`=0 for exactly `run_gap` cycles, then RUN_HI.
- DONE: `done` is set and held.
- `ex_bus` ren is always 0.
- `abort` (priority over start and over handshakes) moves to IDLE next edge. It clears init, run and wen and the counters. Config registers are retained. `done` is not set.
- Config registers persist across sequences; `host_controller` is valid whenever the FSM is idle.

## Timing
- Reset values: every output is 0, config registers are 0, state is IDLE.
- All outputs are registered.
- `init` rises 1 cycle after start is sampled.
- `host_controller` reflects a config write 1 cycle after the handshake.
- `ex_bus` write appears 1 cycle after the data handshake; throughput is 1 word/cycle.
- The first run pulse occurs 1 cycle after the final LOAD (or CFG) handshake.
- `init` falls on the same edge the FSM leaves CFG.
- The pulse period is 1+run_gap cycles.
- `start` in a non-IDLE state is ignored.
- Simultaneous `abort` and `start` in IDLE: stay in IDLE.

## Configuration
- `HOST_SEQ_PERF_EN`: when defined, adds output port `run_cycles` (32 bits).
  - It counts cycles spent in RUN_HI plus RUN_GAP and clears at start.
  - It saturates at all-ones and is held after DONE.
- When undefined, the port and counter are absent.

## Structure
- The shared definitions header holds:
  - state encodings;
  - `ex_bus` field offsets (WEN, REN, ADDR, DATA);
  - the SPM config field offsets (fifo_sel, en, sel, mode per bank).
- Sub-module `host_seq_pulse_gen` implements the RUN_HI/RUN_GAP pulse-count/gap counter with start/abort/finished handshake. The main FSM delegates to it.

## Test plan
- Reset mid-LOAD (rst at word 3 of 10) -> all outputs 0 within the same cycle; state is IDLE; config registers are 0.
- ROWS=4: write idx 0..4 with distinct words, last on idx 4 -> `host_controller` equals the concatenation; `init` is high for exactly the CFG cycles.
- Load with base=0x3FE, len=4 and dat_valid toggling each cycle -> addresses 0x3FE, 0x3FF, 0x000, 0x001; wen high only on the cycle after each handshake.
- num=3, gap=2 -> run pattern 1,0,0,1,0,0,1, then done=1.
- num=2, gap=0, len=0 -> two consecutive run cycles directly after CFG.
- Abort during RUN_GAP -> run=0, busy=0, done=0 next cycle; configs unchanged; PERF build shows the partial run_cycles count.
